tnoc_packet_packer: RTL and testbench
=====================================

# tnoc_packet_packer

Serializes packets from a `tnoc_packet_if` into flits on a `tnoc_flit_if`; it is the transmit counterpart of the packet unpacker. It sits at every network-interface ingress: a local master or slave drives packets in, and the packer emits header and payload flits toward the router. It holds an FSM plus a header-flit counter and forwards flits with zero added latency.

## Interface
- `CONFIG`, `TNOC_DEFAULT_CONFIG`: NoC configuration (widths, VC count, header layout).
- `CHANNELS`, `CONFIG.virtual_channels`: VC lanes on `flit_out_if`.
- `PORT_TYPE`, `TNOC_LOCAL_PORT`: port type of `flit_out_if`.
- `clk`  input  1  clock; all state on rising edge.
- `rst_n`  input  1  reset; synchronous and active-low.
- `packet_in_if`  `tnoc_packet_if.target`  packet header and payload channels from the user side.
- `flit_out_if`  `tnoc_flit_if.initiator`  flit, `valid[CHANNELS]`, `ready[CHANNELS]`, `vc_available[CHANNELS]` (input, unused).

## Operation
- FSM states:
  - IDLE: waits for `header_valid`. Latches `vc` and packet kind on the first header-flit handshake.
  - HEADER: serializes the remaining header flits.
  - PAYLOAD: forwards payload beats.
- Header serialization:
  - Header fields are packed into a `HEADER_FLITS*TNOC_FLIT_DATA_WIDTH` vector: common, then request or response fields.
  - `burst_length` is packed with `pack_burst_length`.
  - Flit i carries slice i.
  - The flit count is `REQUEST_HEADER_FLITS` for request types and `RESPONSE_HEADER_FLITS` otherwise.
- Header flit fields: `flit_type`=header; `head`=1 only on flit 0; `tail`=1 on the last header flit only when the packet has no payload.
- Header handshake: `header_ready` = `ready[vc]` AND last header flit. Upstream holds every header field stable until then.
- Transition after the last header flit: PAYLOAD if `packet_has_payload(packet_type)`, else IDLE.
- Payload flit fields:
  - `flit_type`=payload; `head`=0; `tail`=`payload_last`.
  - Data is a write payload {`data`, `byte_enable`} for request packets.
  - Data is a read payload {`data`, `payload_status`, `response_last`} for response packets.
- Payload handshake: in PAYLOAD, `flit valid[vc]`=`payload_valid` and `payload_ready`=`ready[vc]`.
- Exit from PAYLOAD: an accepted beat with `payload_last`=1 returns the FSM to IDLE.
- Single outstanding packet: `payload_valid` arriving during IDLE or HEADER is not acknowledged (`payload_ready`=0). A new header is not taken until IDLE.
- VC lanes: only lane `vc` asserts `valid`; the other lanes stay 0. For `CHANNELS`==1, `vc` is ignored and lane 0 is used.

## Timing
- Datapath latency: 0 cycles; the flit is combinational from packet inputs and state.
- Flit throughput: one flit per cycle at most.
- Cycles per packet: minimum `HEADER_FLITS + beats` back to back. A no-payload packet of N header flits takes N cycles, and the next header may start the cycle after.
- Reset values (IDLE, count 0):
  - State registers: FSM state = IDLE; header-flit count = 0; latched `vc` = 0.
  - Handshake outputs while `rst_n`=0: all `valid`=0, `header_ready`=0, `payload_ready`=0, regardless of inputs.
- Reset mid-packet: the packet is abandoned and the next cycle starts in IDLE. No tail is emitted.
- Valid rule: `valid` must not drop and flit contents must not change while `ready[vc]`=0. The packer guarantees this only if upstream honours `tnoc_packet_if` stability rules. The bench checks it.
- Simultaneous events: an accepted last payload beat and a pending `header_valid` in the same cycle give IDLE next cycle, and header flit 0 is offered then.
- Counter width: `$clog2(HEADER_FLITS)`, min 1; it resets to 0 after the last header flit.

## Structure
- Shared package (`tnoc_pkg` / packet-flit macros):
  - `tnoc_flit`, `tnoc_common_header`, `tnoc_request_header`, `tnoc_response_header`, `tnoc_write_payload`, `tnoc_read_payload`.
  - `calc_request_header_flits`, `calc_response_header_flits`, `calc_header_flits`.
  - `pack_burst_length`, `packet_has_payload`, `is_request_packet_type`.
- Natural sub-module: `tnoc_flit_vc_demux`, a combinational one-to-`CHANNELS` lane steering block driven by the latched `vc`. With `CHANNELS`==1 it is bypassed with `tnoc_flit_if_renamer`.

## Test plan
- Read request, vc=0, `ready`=1 throughout -> exactly `REQUEST_HEADER_FLITS` flits. The first has `head`=1, the last has `tail`=1, and `header_ready` pulses once on the final cycle.
- Write request, burst_length 4, data 0x11..0x44, byte_enable all-ones -> header flits then 4 payload flits. Only the 4th has `tail`=1; `payload_ready` pulses 4 times.
- Read response, 2 beats, status OKAY, `response_last` on beat 2 -> payload flits carry status and `response_last`. `tail` follows `payload_last`.
- `ready` toggles 1,0,0,1 mid-header and mid-payload -> flit held stable while stalled, no flit dropped or duplicated, counts match.
- `CHANNELS`=2, packet vc=1 -> only `valid[1]` asserts, and lane 0 `ready` has no effect.
- `rst_n` low for 1 cycle after payload beat 2 of 4 -> all valids/readys 0 during reset. The next packet starts with a `head` flit, count 0.

Source files
------------

// File: rtl/tnoc_packet_packer_pkg.sv
// Shared NoC packet/flit definitions for the packet packer slice.
// Holds the flit, header and payload layouts, the header-flit count helpers
// and the packet-type predicates used by the packer and its lane demux.
package tnoc_packet_packer_pkg;

    localparam int TNOC_FLIT_DATA_WIDTH           = 40;
    localparam int TNOC_DATA_WIDTH                = 32;
    localparam int TNOC_BYTE_ENABLE_WIDTH         = TNOC_DATA_WIDTH / 8;
    localparam int TNOC_ADDRESS_WIDTH             = 32;
    localparam int TNOC_ID_WIDTH                  = 4;
    localparam int TNOC_VC_FIELD_WIDTH            = 2;
    localparam int TNOC_TAG_WIDTH                 = 3;
    localparam int TNOC_BURST_LENGTH_WIDTH        = 5;
    localparam int TNOC_PACKED_BURST_LENGTH_WIDTH = 4;
    localparam int TNOC_BURST_SIZE_WIDTH          = 2;
    localparam int TNOC_STATUS_WIDTH              = 2;

    // Bit 7 marks a response, bit 6 marks a packet that carries payload.
    typedef enum logic [7:0] {
        TNOC_READ               = 8'h01,
        TNOC_WRITE              = 8'h41,
        TNOC_RESPONSE           = 8'h81,
        TNOC_RESPONSE_WITH_DATA = 8'hC1
    } tnoc_packet_type_t;

    typedef enum logic [1:0] {
        TNOC_OKAY         = 2'b00,
        TNOC_EXOKAY       = 2'b01,
        TNOC_SLAVE_ERROR  = 2'b10,
        TNOC_DECODE_ERROR = 2'b11
    } tnoc_response_status_t;

    typedef enum logic {
        TNOC_HEADER_FLIT  = 1'b0,
        TNOC_PAYLOAD_FLIT = 1'b1
    } tnoc_flit_type_t;

    typedef struct packed {
        tnoc_flit_type_t                  flit_type;
        logic                             head;
        logic                             tail;
        logic [TNOC_FLIT_DATA_WIDTH-1:0]  data;
    } tnoc_flit_t;

    typedef struct packed {
        logic [7:0]                       packet_type;
        logic [TNOC_ID_WIDTH-1:0]         destination_id;
        logic [TNOC_ID_WIDTH-1:0]         source_id;
        logic [TNOC_VC_FIELD_WIDTH-1:0]   vc;
        logic [TNOC_TAG_WIDTH-1:0]        tag;
    } tnoc_common_header_t;

    typedef struct packed {
        logic [TNOC_ADDRESS_WIDTH-1:0]             address;
        logic [TNOC_PACKED_BURST_LENGTH_WIDTH-1:0] burst_length;
        logic [TNOC_BURST_SIZE_WIDTH-1:0]          burst_size;
    } tnoc_request_header_t;

    typedef struct packed {
        logic [TNOC_STATUS_WIDTH-1:0] status;
    } tnoc_response_header_t;

    typedef struct packed {
        logic [TNOC_DATA_WIDTH-1:0]        data;
        logic [TNOC_BYTE_ENABLE_WIDTH-1:0] byte_enable;
    } tnoc_write_payload_t;

    typedef struct packed {
        logic [TNOC_DATA_WIDTH-1:0]   data;
        logic [TNOC_STATUS_WIDTH-1:0] status;
        logic                         response_last;
    } tnoc_read_payload_t;

    function automatic int calc_request_header_flits();
        return ($bits(tnoc_common_header_t) + $bits(tnoc_request_header_t)
                + TNOC_FLIT_DATA_WIDTH - 1) / TNOC_FLIT_DATA_WIDTH;
    endfunction

    function automatic int calc_response_header_flits();
        return ($bits(tnoc_common_header_t) + $bits(tnoc_response_header_t)
                + TNOC_FLIT_DATA_WIDTH - 1) / TNOC_FLIT_DATA_WIDTH;
    endfunction

    function automatic int calc_header_flits();
        return (calc_request_header_flits() > calc_response_header_flits())
               ? calc_request_header_flits() : calc_response_header_flits();
    endfunction

    localparam int REQUEST_HEADER_FLITS  = calc_request_header_flits();
    localparam int RESPONSE_HEADER_FLITS = calc_response_header_flits();
    localparam int HEADER_FLITS          = calc_header_flits();
    localparam int HEADER_COUNT_WIDTH    = (HEADER_FLITS > 1) ? $clog2(HEADER_FLITS) : 1;

    // Bursts run 1..16; 16 wraps to 0 in the 4-bit header field.
    function automatic logic [TNOC_PACKED_BURST_LENGTH_WIDTH-1:0] pack_burst_length(
        input logic [TNOC_BURST_LENGTH_WIDTH-1:0] burst_length
    );
        return burst_length[TNOC_PACKED_BURST_LENGTH_WIDTH-1:0];
    endfunction

    function automatic logic is_request_packet_type(input logic [7:0] packet_type);
        return !packet_type[7];
    endfunction

    function automatic logic packet_has_payload(input logic [7:0] packet_type);
        return packet_type[6];
    endfunction

endpackage

// File: rtl/tnoc_packet_packer_vc_demux.sv
// Combinational one-to-CHANNELS lane steering for the packer's flit valid.
// Ports: vc_sel (lane index), valid (flit valid), lane_valid (per-lane valid),
// lane_ready (per-lane ready from router), ready (ready of the selected lane).
// With a single channel the lane index is ignored and lane 0 is wired through.
module tnoc_packet_packer_vc_demux #(
    parameter int CHANNELS = 2,
    parameter int VC_WIDTH = 1
) (
    input  logic [VC_WIDTH-1:0] vc_sel,
    input  logic                valid,
    output logic [CHANNELS-1:0] lane_valid,
    input  logic [CHANNELS-1:0] lane_ready,
    output logic                ready
);

    generate
        if (CHANNELS == 1) begin : g_bypass
            logic unused_vc_sel;
            assign unused_vc_sel = ^vc_sel;
            assign lane_valid    = valid;
            assign ready         = lane_ready[0];
        end else begin : g_demux
            always_comb begin
                lane_valid = '0;
                ready      = 1'b0;
                for (int i = 0; i < CHANNELS; i++) begin
                    if (vc_sel == VC_WIDTH'(i)) begin
                        lane_valid[i] = valid;
                        ready         = lane_ready[i];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/tnoc_packet_packer.sv
// Packet-to-flit serializer at the network-interface ingress.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   header_* / fields     packet header channel (valid/ready + header fields)
//   payload_*             payload channel (valid/ready, data, byte_enable,
//                         status, response_last, payload_last)
//   flit_valid/flit_ready per-lane flit handshake toward the router
//   vc_available          per-lane credit hint, not used by this block
//   flit_out              flit shared by all lanes
// Flits are combinational from the packet inputs and FSM state (no latency).
//
// state   | meaning
// IDLE    | waiting for header_valid; offers header flit 0 straight from inputs
// HEADER  | serializing header flits 1..N-1 on the latched vc
// PAYLOAD | forwarding payload beats until an accepted payload_last
module tnoc_packet_packer
    import tnoc_packet_packer_pkg::*;
#(
    parameter int CHANNELS = 2,
    localparam int VC_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   header_valid,
    output logic                                   header_ready,
    input  logic [7:0]                             packet_type,
    input  logic [TNOC_ID_WIDTH-1:0]               destination_id,
    input  logic [TNOC_ID_WIDTH-1:0]               source_id,
    input  logic [VC_WIDTH-1:0]                    vc,
    input  logic [TNOC_TAG_WIDTH-1:0]              tag,
    input  logic [TNOC_ADDRESS_WIDTH-1:0]          address,
    input  logic [TNOC_BURST_LENGTH_WIDTH-1:0]     burst_length,
    input  logic [TNOC_BURST_SIZE_WIDTH-1:0]       burst_size,
    input  logic [TNOC_STATUS_WIDTH-1:0]           status,
    input  logic                                   payload_valid,
    output logic                                   payload_ready,
    input  logic [TNOC_DATA_WIDTH-1:0]             payload_data,
    input  logic [TNOC_BYTE_ENABLE_WIDTH-1:0]      byte_enable,
    input  logic [TNOC_STATUS_WIDTH-1:0]           payload_status,
    input  logic                                   response_last,
    input  logic                                   payload_last,
    output logic [CHANNELS-1:0]                    flit_valid,
    input  logic [CHANNELS-1:0]                    flit_ready,
    input  logic [CHANNELS-1:0]                    vc_available,
    output tnoc_flit_t                             flit_out
);

    localparam int HEADER_BITS = HEADER_FLITS * TNOC_FLIT_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD
    } state_t;

    state_t                                         state;
    logic [HEADER_COUNT_WIDTH-1:0]                  count;
    logic [VC_WIDTH-1:0]                            vc_q;
    logic                                           request_q;

    logic [VC_WIDTH-1:0]                            vc_sel;
    logic                                           ready_sel;
    logic                                           valid_sel;
    logic                                           in_header;
    logic                                           last_header;
    logic                                           header_accept;
    logic                                           payload_accept;
    tnoc_common_header_t                            common_header;
    tnoc_request_header_t                           request_header;
    tnoc_response_header_t                          response_header;
    tnoc_write_payload_t                            write_payload;
    tnoc_read_payload_t                             read_payload;
    logic [HEADER_FLITS-1:0][TNOC_FLIT_DATA_WIDTH-1:0] header_words;

    logic unused_vc_available;
    assign unused_vc_available = ^vc_available;

    // Flit 0 goes out in IDLE before vc is latched, so steer on the live vc there.
    assign vc_sel    = (CHANNELS == 1) ? '0 : ((state == IDLE) ? vc : vc_q);
    assign in_header = (state == IDLE) || (state == HEADER);

    always_comb begin
        if (is_request_packet_type(packet_type)) begin
            last_header = (count == HEADER_COUNT_WIDTH'(REQUEST_HEADER_FLITS - 1));
        end else begin
            last_header = (count == HEADER_COUNT_WIDTH'(RESPONSE_HEADER_FLITS - 1));
        end
    end

    always_comb begin
        valid_sel = 1'b0;
        if (rst_n) begin
            if (in_header) begin
                valid_sel = header_valid;
            end else if (state == PAYLOAD) begin
                valid_sel = payload_valid;
            end
        end
    end

    tnoc_packet_packer_vc_demux #(
        .CHANNELS (CHANNELS),
        .VC_WIDTH (VC_WIDTH)
    ) u_vc_demux (
        .vc_sel     (vc_sel),
        .valid      (valid_sel),
        .lane_valid (flit_valid),
        .lane_ready (flit_ready),
        .ready      (ready_sel)
    );

    assign header_accept  = rst_n && in_header && header_valid && ready_sel;
    assign header_ready   = header_accept && last_header;
    assign payload_ready  = rst_n && (state == PAYLOAD) && ready_sel;
    assign payload_accept = payload_ready && payload_valid;

    always_comb begin
        common_header.packet_type      = packet_type;
        common_header.destination_id   = destination_id;
        common_header.source_id        = source_id;
        common_header.vc               = TNOC_VC_FIELD_WIDTH'(vc);
        common_header.tag              = tag;
        request_header.address         = address;
        request_header.burst_length    = pack_burst_length(burst_length);
        request_header.burst_size      = burst_size;
        response_header.status         = status;
        write_payload.data             = payload_data;
        write_payload.byte_enable      = byte_enable;
        read_payload.data              = payload_data;
        read_payload.status            = payload_status;
        read_payload.response_last     = response_last;
        if (is_request_packet_type(packet_type)) begin
            header_words = HEADER_BITS'({request_header, common_header});
        end else begin
            header_words = HEADER_BITS'({response_header, common_header});
        end
    end

    always_comb begin
        if (in_header) begin
            flit_out.flit_type = TNOC_HEADER_FLIT;
            flit_out.head      = (count == '0);
            flit_out.tail      = last_header && !packet_has_payload(packet_type);
            flit_out.data      = header_words[count];
        end else begin
            flit_out.flit_type = TNOC_PAYLOAD_FLIT;
            flit_out.head      = 1'b0;
            flit_out.tail      = payload_last;
            flit_out.data      = request_q ? TNOC_FLIT_DATA_WIDTH'(write_payload)
                                           : TNOC_FLIT_DATA_WIDTH'(read_payload);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            vc_q      <= '0;
            request_q <= 1'b0;
        end else begin
            case (state)
                IDLE, HEADER: begin
                    if (header_accept) begin
                        if (state == IDLE) begin
                            vc_q      <= vc_sel;
                            request_q <= is_request_packet_type(packet_type);
                        end
                        if (last_header) begin
                            count <= '0;
                            state <= packet_has_payload(packet_type) ? PAYLOAD : IDLE;
                        end else begin
                            count <= count + HEADER_COUNT_WIDTH'(1);
                            state <= HEADER;
                        end
                    end
                end
                PAYLOAD: begin
                    if (payload_accept && payload_last) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tnoc_packet_packer.sv
// Self-checking bench for tnoc_packet_packer with two VC lanes.
module tb_tnoc_packet_packer;
    import tnoc_packet_packer_pkg::*;

    localparam int CH = 2;
    // Header layout: 21-bit common + 38-bit request -> 2 flits of 40 bits;
    // 21-bit common + 2-bit response -> 1 flit.
    localparam int REQ_NH  = 2;
    localparam int RESP_NH = 1;
    localparam logic [7:0] T_READ      = 8'h01;
    localparam logic [7:0] T_WRITE     = 8'h41;
    localparam logic [7:0] T_RESP      = 8'h81;
    localparam logic [7:0] T_RESP_DATA = 8'hC1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        header_valid, header_ready;
    logic [7:0]  packet_type;
    logic [3:0]  destination_id, source_id;
    logic        vc;
    logic [2:0]  tag;
    logic [31:0] address;
    logic [4:0]  burst_length;
    logic [1:0]  burst_size, status;
    logic        payload_valid, payload_ready;
    logic [31:0] payload_data;
    logic [3:0]  byte_enable;
    logic [1:0]  payload_status;
    logic        response_last, payload_last;
    logic [CH-1:0] flit_valid, flit_ready, vc_available;
    tnoc_flit_t  flit_out;

    int checks = 0;
    int failures = 0;

    logic [31:0] beat_data [16];
    logic [3:0]  beat_be   [16];
    logic [1:0]  beat_st   [16];

    tnoc_packet_packer #(.CHANNELS(CH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .header_valid   (header_valid),
        .header_ready   (header_ready),
        .packet_type    (packet_type),
        .destination_id (destination_id),
        .source_id      (source_id),
        .vc             (vc),
        .tag            (tag),
        .address        (address),
        .burst_length   (burst_length),
        .burst_size     (burst_size),
        .status         (status),
        .payload_valid  (payload_valid),
        .payload_ready  (payload_ready),
        .payload_data   (payload_data),
        .byte_enable    (byte_enable),
        .payload_status (payload_status),
        .response_last  (response_last),
        .payload_last   (payload_last),
        .flit_valid     (flit_valid),
        .flit_ready     (flit_ready),
        .vc_available   (vc_available),
        .flit_out       (flit_out)
    );

    // rmode: 0 ready always high, 1 ready pattern 1,0,0,1, 2 random ready.
    // reset_at: number of accepted flits after which rst_n is pulsed (-1 none).
    task automatic run_packet(input logic [7:0] ptype, input logic pvc, input int beats,
                              input int rmode, input logic hv_pay, input int reset_at,
                              output int cycles, output int hr_n, output int pr_n);
        logic [3:0]  dest, src;
        logic [2:0]  tg, sz_unused;
        logic [31:0] addr;
        logic [4:0]  bl;
        logic [1:0]  sz, st;
        logic [20:0] common;
        logic [79:0] vec;
        logic [42:0] exp_q[$];
        logic [42:0] exp_flit;
        logic [CH-1:0] exp_valid;
        bit isreq, haspay, hdr_phase, rdy, exp_hr, exp_pr, did_reset;
        int nh, total, sent, beat;
        dest = 4'($urandom); src = 4'($urandom); tg = 3'($urandom);
        addr = $urandom; sz = 2'($urandom); st = 2'($urandom);
        sz_unused = '0;
        isreq  = !ptype[7];
        haspay = ptype[6];
        bl = (isreq && haspay) ? 5'(beats) : 5'($urandom_range(1, 16));
        nh = isreq ? REQ_NH : RESP_NH;
        common = {ptype, dest, src, 1'b0, pvc, tg};
        if (isreq) vec = {21'b0, addr, bl[3:0], sz, common};
        else       vec = {57'b0, st, common};
        exp_q.delete();
        for (int i = 0; i < nh; i++)
            exp_q.push_back({1'b0, (i == 0), ((i == nh - 1) && !haspay), vec[i*40 +: 40]});
        if (haspay) begin
            for (int b = 0; b < beats; b++) begin
                if (isreq) exp_q.push_back({1'b1, 1'b0, (b == beats - 1), 4'b0, beat_data[b], beat_be[b]});
                else       exp_q.push_back({1'b1, 1'b0, (b == beats - 1), 5'b0, beat_data[b], beat_st[b], (b == beats - 1)});
            end
        end
        total = exp_q.size();
        sent = 0; cycles = 0; hr_n = 0; pr_n = 0; did_reset = 0;
        while (sent < total && cycles < 200) begin
            @(negedge clk);
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = ((cycles % 4) == 0) || ((cycles % 4) == 3);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            hdr_phase = (sent < nh);
            beat = hdr_phase ? 0 : sent - nh;
            header_valid   = hdr_phase || (hv_pay && haspay);
            packet_type    = ptype; destination_id = dest; source_id = src;
            vc             = pvc;   tag = tg; address = addr; burst_length = bl;
            burst_size     = sz;    status = st;
            payload_valid  = haspay;
            payload_data   = beat_data[beat];
            byte_enable    = beat_be[beat];
            payload_status = beat_st[beat];
            payload_last   = haspay && (beat == beats - 1);
            response_last  = haspay && (beat == beats - 1);
            flit_ready[pvc]  = rdy;
            flit_ready[!pvc] = 1'($urandom);
            if (reset_at >= 0 && sent == reset_at) rst_n = 1'b0;
            #1;
            cycles++;
            if (!rst_n) begin
                checks++;
                if (flit_valid !== '0) begin
                    failures++; $display("FAIL rst_valid got=%b want=00", flit_valid);
                end
                checks++;
                if (header_ready !== 1'b0) begin
                    failures++; $display("FAIL rst_header_ready got=%b want=0", header_ready);
                end
                checks++;
                if (payload_ready !== 1'b0) begin
                    failures++; $display("FAIL rst_payload_ready got=%b want=0", payload_ready);
                end
                @(negedge clk);
                rst_n = 1'b1; header_valid = 1'b0; payload_valid = 1'b0;
                did_reset = 1;
                break;
            end
            exp_valid = '0; exp_valid[pvc] = 1'b1;
            exp_flit = exp_q[sent];
            exp_hr = hdr_phase && rdy && (sent == nh - 1);
            exp_pr = !hdr_phase && rdy;
            checks++;
            if (flit_valid !== exp_valid) begin
                failures++; $display("FAIL lane_valid flit=%0d got=%b want=%b", sent, flit_valid, exp_valid);
            end
            checks++;
            if (flit_out !== exp_flit) begin
                failures++; $display("FAIL flit flit=%0d got=%h want=%h", sent, flit_out, exp_flit);
            end
            checks++;
            if (header_ready !== exp_hr) begin
                failures++; $display("FAIL header_ready flit=%0d got=%b want=%b", sent, header_ready, exp_hr);
            end
            checks++;
            if (payload_ready !== exp_pr) begin
                failures++; $display("FAIL payload_ready flit=%0d got=%b want=%b", sent, payload_ready, exp_pr);
            end
            if (header_ready === 1'b1) hr_n++;
            if (payload_ready === 1'b1) pr_n++;
            if (rdy) sent++;
        end
        if (!did_reset) begin
            checks++;
            if (sent != total) begin
                failures++; $display("FAIL timeout sent=%0d want=%0d", sent, total);
            end
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        header_valid = 1'b0; payload_valid = 1'b0; flit_ready = '0;
    endtask

    task automatic fill_beats(input int n);
        for (int i = 0; i < 16; i++) begin
            beat_data[i] = $urandom; beat_be[i] = 4'($urandom); beat_st[i] = 2'($urandom);
        end
        if (n > 16) $display("fill_beats: n too large");
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        header_valid = 1'b1; payload_valid = 1'b1; flit_ready = '1;
        packet_type = T_WRITE; vc = 1'b0; payload_last = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (flit_valid !== '0) begin
            failures++; $display("FAIL reset_valid got=%b want=00", flit_valid);
        end
        checks++;
        if (header_ready !== 1'b0) begin
            failures++; $display("FAIL reset_header_ready got=%b want=0", header_ready);
        end
        checks++;
        if (payload_ready !== 1'b0) begin
            failures++; $display("FAIL reset_payload_ready got=%b want=0", payload_ready);
        end
        @(negedge clk);
        rst_n = 1'b1; header_valid = 1'b0;
        #1;
        // payload offered in IDLE must not be acknowledged
        checks++;
        if (payload_ready !== 1'b0 || flit_valid !== '0) begin
            failures++; $display("FAIL idle_payload got_ready=%b got_valid=%b want=0/00", payload_ready, flit_valid);
        end
        go_idle();
    endtask

    task automatic test_read_request();
        int cyc, hr, pr;
        run_packet(T_READ, 1'b0, 0, 0, 1'b0, -1, cyc, hr, pr);
        checks++;
        if (cyc != REQ_NH || hr != 1 || pr != 0) begin
            failures++; $display("FAIL read_request cycles=%0d hr=%0d pr=%0d want=%0d/1/0", cyc, hr, pr, REQ_NH);
        end
    endtask

    task automatic test_write_request();
        int cyc, hr, pr;
        fill_beats(4);
        for (int i = 0; i < 4; i++) begin
            beat_data[i] = 32'h11 * (i + 1); beat_be[i] = 4'hF;
        end
        run_packet(T_WRITE, 1'b0, 4, 0, 1'b0, -1, cyc, hr, pr);
        checks++;
        if (cyc != REQ_NH + 4 || hr != 1 || pr != 4) begin
            failures++; $display("FAIL write_request cycles=%0d hr=%0d pr=%0d want=%0d/1/4", cyc, hr, pr, REQ_NH + 4);
        end
    endtask

    task automatic test_read_response();
        int cyc, hr, pr;
        fill_beats(2);
        beat_st[0] = TNOC_OKAY; beat_st[1] = TNOC_OKAY;
        run_packet(T_RESP_DATA, 1'b0, 2, 0, 1'b0, -1, cyc, hr, pr);
        checks++;
        if (cyc != RESP_NH + 2 || hr != 1 || pr != 2) begin
            failures++; $display("FAIL read_response cycles=%0d hr=%0d pr=%0d want=%0d/1/2", cyc, hr, pr, RESP_NH + 2);
        end
    endtask

    task automatic test_stall();
        int cyc, hr, pr;
        fill_beats(4);
        run_packet(T_WRITE, 1'b0, 4, 1, 1'b0, -1, cyc, hr, pr);
        checks++;
        if (hr != 1) begin
            failures++; $display("FAIL stall_header_ready pulses=%0d want=1", hr);
        end
        fill_beats(3);
        run_packet(T_RESP_DATA, 1'b1, 3, 1, 1'b0, -1, cyc, hr, pr);
    endtask

    task automatic test_vc1();
        int cyc, hr, pr;
        fill_beats(3);
        run_packet(T_WRITE, 1'b1, 3, 2, 1'b0, -1, cyc, hr, pr);
        run_packet(T_READ, 1'b1, 0, 2, 1'b0, -1, cyc, hr, pr);
    endtask

    task automatic test_back_to_back();
        int cyc, hr, pr;
        run_packet(T_RESP, 1'b0, 0, 0, 1'b0, -1, cyc, hr, pr);
        run_packet(T_RESP, 1'b1, 0, 0, 1'b0, -1, cyc, hr, pr);
        checks++;
        if (cyc != RESP_NH) begin
            failures++; $display("FAIL b2b_response cycles=%0d want=%0d", cyc, RESP_NH);
        end
        fill_beats(2);
        run_packet(T_WRITE, 1'b0, 2, 0, 1'b1, -1, cyc, hr, pr);
        run_packet(T_READ, 1'b1, 0, 0, 1'b0, -1, cyc, hr, pr);
        checks++;
        if (cyc != REQ_NH) begin
            failures++; $display("FAIL b2b_after_payload cycles=%0d want=%0d", cyc, REQ_NH);
        end
        go_idle();
    endtask

    task automatic test_reset_mid_packet();
        int cyc, hr, pr;
        fill_beats(4);
        run_packet(T_WRITE, 1'b1, 4, 0, 1'b0, REQ_NH + 2, cyc, hr, pr);
        run_packet(T_READ, 1'b0, 0, 0, 1'b0, -1, cyc, hr, pr);
        checks++;
        if (cyc != REQ_NH) begin
            failures++; $display("FAIL after_reset cycles=%0d want=%0d", cyc, REQ_NH);
        end
        go_idle();
    endtask

    task automatic test_random();
        int cyc, hr, pr, beats, k;
        logic [7:0] t;
        for (int n = 0; n < 25; n++) begin
            k = $urandom_range(0, 3);
            case (k)
                0:       t = T_READ;
                1:       t = T_WRITE;
                2:       t = T_RESP;
                default: t = T_RESP_DATA;
            endcase
            beats = t[6] ? $urandom_range(1, 4) : 0;
            fill_beats(beats);
            run_packet(t, 1'($urandom), beats, 2, 1'($urandom), -1, cyc, hr, pr);
            checks++;
            if (hr != 1) begin
                failures++; $display("FAIL random_header_ready pkt=%0d pulses=%0d want=1", n, hr);
            end
            if ($urandom_range(0, 3) == 0) go_idle();
        end
        go_idle();
    endtask

    initial begin
        rst_n = 1'b0; header_valid = 1'b0; payload_valid = 1'b0;
        packet_type = T_READ; destination_id = '0; source_id = '0; vc = 1'b0;
        tag = '0; address = '0; burst_length = 5'd1; burst_size = '0; status = '0;
        payload_data = '0; byte_enable = '0; payload_status = '0;
        response_last = 1'b0; payload_last = 1'b0;
        flit_ready = '0; vc_available = '1;
        for (int i = 0; i < 16; i++) begin
            beat_data[i] = '0; beat_be[i] = '0; beat_st[i] = '0;
        end
        test_reset();
        test_read_request();
        test_write_request();
        test_read_response();
        test_stall();
        test_vc1();
        test_back_to_back();
        test_reset_mid_packet();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
